csr_file: RTL

//  Machine-mode CSR storage for the core. Holds machine CSRs, the 64-bit cycle/instret counters and trap/mret state updates.
//  Its registered write port is driven by writeback. The combinational read port returns pre-write contents on
//  r_csr_data_o; the downstream bypass stage forwards same-cycle writes on top of it.

---
 rtl/csr_file_pkg.sv | 46 ++++
 rtl/csr_file_counter64.sv | 34 +++
 rtl/csr_file.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/csr_file_pkg.sv
// csr_file_pkg: shared CSR address map, bit positions, write masks and read-formatting helpers
// for the machine-mode CSR file.
package csr_file_pkg;

  typedef logic [11:0] csr_addr_t;
  typedef logic [31:0] csr_data_t;

  // Machine CSR addresses
  localparam csr_addr_t CSR_MSTATUS   = 12'h300;
  localparam csr_addr_t CSR_MIE       = 12'h304;
  localparam csr_addr_t CSR_MTVEC     = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
  localparam csr_addr_t CSR_MEPC      = 12'h341;
  localparam csr_addr_t CSR_MCAUSE    = 12'h342;
  localparam csr_addr_t CSR_MTVAL     = 12'h343;
  localparam csr_addr_t CSR_MIP       = 12'h344;
  localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
  localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
  localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
  localparam csr_addr_t CSR_MHARTID   = 12'hF14;

  // mstatus bit positions
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

  // mie/mip bit positions (external, timer, software)
  localparam int unsigned IRQ_MEI_BIT = 11;
  localparam int unsigned IRQ_MTI_BIT = 7;
  localparam int unsigned IRQ_MSI_BIT = 3;

  // Writable-bit masks
  localparam csr_data_t MSTATUS_WMASK = 32'h0000_0088;
  localparam csr_data_t MIE_WMASK     = 32'h0000_0888;

  // Pack the three stored interrupt bits {ext, tmr, sw} into their mie/mip positions
  function automatic csr_data_t irq_word(input logic [2:0] bits);
    return {20'b0, bits[2], 3'b0, bits[1], 3'b0, bits[0], 3'b0};
  endfunction

  // mstatus image: MPP hardwired to machine mode, only MIE/MPIE stored
  function automatic csr_data_t mstatus_word(input logic mpie, input logic mie);
    return {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// csr_counter64: 64-bit counter with independently writable halves; a write to
// either half suppresses the increment for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count_o
);

  logic [63:0] count_d, count_q;

  // Next count: software write replaces a half, otherwise increment with carry
  always_comb begin
    count_d = count_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) count_d[31:0]  = wdata;
      if (wr_hi) count_d[63:32] = wdata;
    end else if (inc) begin
      count_d = count_q + 64'd1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage with trap/mret updates, interrupt pending
// and optional 64-bit cycle/instret counters (enabled by CSR_COUNTERS_EN).
// Reads are combinational and return the pre-write contents.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_csr_req_i,
  input  logic [11:0] w_csr_addr_i,
  input  logic [31:0] w_csr_data_i,
  input  logic [11:0] r_csr_addr_i,
  output logic [31:0] r_csr_data_o,
  input  logic        trap_req_i,
  input  logic [31:0] trap_epc_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_i,
  input  logic        retire_i,
  input  logic        ext_irq_i,
  input  logic        tmr_irq_i,
  input  logic        sw_irq_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending_o
);

  logic        st_mie_d,  st_mie_q;
  logic        st_mpie_d, st_mpie_q;
  logic [2:0]  mie_d,     mie_q;      // {MEIE, MTIE, MSIE}
  logic [2:0]  mip_d,     mip_q;      // {MEIP, MTIP, MSIP}
  logic [29:0] mtvec_d,   mtvec_q;    // bits [31:2]
  logic [31:0] mscratch_d, mscratch_q;
  logic [29:0] mepc_d,    mepc_q;     // bits [31:2]
  logic [31:0] mcause_d,  mcause_q;
  logic [31:0] mtval_d,   mtval_q;

  logic        sw_wr;
  logic [63:0] mcycle, minstret;

  // A trap drops the software write entirely, including counter writes
  assign sw_wr = w_csr_req_i && !trap_req_i;

  // Next-state for the machine CSRs: trap > mret > software write
  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mip_d      = {ext_irq_i, tmr_irq_i, sw_irq_i};
    if (trap_req_i) begin
      mepc_d    = trap_epc_i[31:2];
      mcause_d  = trap_cause_i;
      mtval_d   = trap_tval_i;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else begin
      if (sw_wr) begin
        unique case (w_csr_addr_i)
          CSR_MSTATUS: begin
            st_mie_d  = w_csr_data_i[MSTATUS_MIE_BIT];
            st_mpie_d = w_csr_data_i[MSTATUS_MPIE_BIT];
          end
          CSR_MIE: mie_d = {w_csr_data_i[IRQ_MEI_BIT], w_csr_data_i[IRQ_MTI_BIT],
                            w_csr_data_i[IRQ_MSI_BIT]};
          CSR_MTVEC:    mtvec_d    = w_csr_data_i[31:2];
          CSR_MSCRATCH: mscratch_d = w_csr_data_i;
          CSR_MEPC:     mepc_d     = w_csr_data_i[31:2];
          CSR_MCAUSE:   mcause_d   = w_csr_data_i;
          CSR_MTVAL:    mtval_d    = w_csr_data_i;
          default: ;
        endcase
      end
      // Applied after the write so a concurrent mstatus write loses to mret
      if (mret_i) begin
        st_mie_d  = st_mpie_q;
        st_mpie_d = 1'b1;
      end
    end
  end

  // CSR registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= MTVEC_RESET[31:2];
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mip_q      <= mip_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic unused_epc_lsbs;
  assign unused_epc_lsbs = ^trap_epc_i[1:0];

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc     (1'b1),
    .wr_lo   (sw_wr && (w_csr_addr_i == CSR_MCYCLE)),
    .wr_hi   (sw_wr && (w_csr_addr_i == CSR_MCYCLEH)),
    .wdata   (w_csr_data_i),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc     (retire_i),
    .wr_lo   (sw_wr && (w_csr_addr_i == CSR_MINSTRET)),
    .wr_hi   (sw_wr && (w_csr_addr_i == CSR_MINSTRETH)),
    .wdata   (w_csr_data_i),
    .count_o (minstret)
  );
`else
  logic unused_inputs;
  assign unused_inputs = retire_i ^ (^trap_epc_i[1:0]);
  assign mcycle   = '0;
  assign minstret = '0;
`endif

  // Combinational read mux over registered state (pre-write value)
  always_comb begin
    r_csr_data_o = '0;
    unique case (r_csr_addr_i)
      CSR_MSTATUS:   r_csr_data_o = mstatus_word(st_mpie_q, st_mie_q);
      CSR_MIE:       r_csr_data_o = irq_word(mie_q);
      CSR_MTVEC:     r_csr_data_o = {mtvec_q, 2'b00};
      CSR_MSCRATCH:  r_csr_data_o = mscratch_q;
      CSR_MEPC:      r_csr_data_o = {mepc_q, 2'b00};
      CSR_MCAUSE:    r_csr_data_o = mcause_q;
      CSR_MTVAL:     r_csr_data_o = mtval_q;
      CSR_MIP:       r_csr_data_o = irq_word(mip_q);
      CSR_MCYCLE:    r_csr_data_o = mcycle[31:0];
      CSR_MINSTRET:  r_csr_data_o = minstret[31:0];
      CSR_MCYCLEH:   r_csr_data_o = mcycle[63:32];
      CSR_MINSTRETH: r_csr_data_o = minstret[63:32];
      CSR_MHARTID:   r_csr_data_o = MHARTID;
      default:       r_csr_data_o = '0;
    endcase
  end

  assign mtvec_o       = {mtvec_q, 2'b00};
  assign mepc_o        = {mepc_q, 2'b00};
  assign irq_pending_o = st_mie_q && |(mie_q & mip_q);

endmodule
